// File: rtl/decode_stage.sv
// MIPS ID stage: register file, beq/bne/j resolution, load-use and branch
// hazard detection, and the ID/EX pipeline register feeding execute.
module decode_stage #(
   parameter int NB_BITS = 32,
   parameter int NB_REG  = 5,
   parameter int N_REGS  = 32,
   parameter int NB_JMP  = 26,
   parameter int NB_CTRL = 6
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NB_BITS-1:0] i_if_id_pc,
   input  logic [NB_BITS-1:0] i_if_id_instr,
   input  logic [NB_REG-1:0]  i_wb_addr,
   input  logic [NB_BITS-1:0] i_wb_data,
   input  logic               i_wb_we,
   input  logic [NB_REG-1:0]  i_mem_rd,
   input  logic               i_mem_reg_we,
   input  logic               i_mem_mem_read,
   input  logic [NB_BITS-1:0] i_mem_alu_data,
   input  logic               i_debug,
   input  logic               i_step,
   input  logic [NB_REG-1:0]  i_reg_addr_debug,
   output logic [NB_BITS-1:0] o_id_ex_rs_data,
   output logic [NB_BITS-1:0] o_id_ex_rt_data,
   output logic [NB_BITS-1:0] o_id_ex_imm,
   output logic [NB_REG-1:0]  o_id_ex_rs,
   output logic [NB_REG-1:0]  o_id_ex_rt,
   output logic [NB_REG-1:0]  o_id_ex_rd,
   output logic [5:0]         o_id_ex_opcode,
   output logic [NB_CTRL-1:0] o_id_ex_ctrl,
   output logic [NB_BITS-1:0] o_brq_addr,
   output logic [NB_BITS-1:0] o_jmp_addr,
   output logic               o_ctr_beq,
   output logic               o_ctr_jmp,
   output logic               o_ctr_flush,
   output logic               o_pc_we,
   output logic               o_if_id_we,
   output logic [NB_BITS-1:0] o_reg_data_debug
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [NB_CTRL-1:0] CTRL_RTYPE = NB_CTRL'(6'b100001);
   localparam logic [NB_CTRL-1:0] CTRL_IMM   = NB_CTRL'(6'b100010);
   localparam logic [NB_CTRL-1:0] CTRL_LW    = NB_CTRL'(6'b110110);
   localparam logic [NB_CTRL-1:0] CTRL_SW    = NB_CTRL'(6'b001010);

   localparam int C_REG_WE   = 5;
   localparam int C_MEM_READ = 4;
   localparam int C_REG_DST  = 0;

   function automatic logic [NB_BITS-1:0] rf_bypass(
      input logic [NB_REG-1:0]  addr,
      input logic [NB_BITS-1:0] stored,
      input logic               we,
      input logic [NB_REG-1:0]  waddr,
      input logic [NB_BITS-1:0] wdata
   );
      if (addr == '0)
         return '0;
      if (we && (waddr == addr))
         return wdata;
      return stored;
   endfunction

   function automatic logic reg_hit(
      input logic [NB_REG-1:0] dst,
      input logic [NB_REG-1:0] a,
      input logic [NB_REG-1:0] b
   );
      return (dst != '0) && ((dst == a) || (dst == b));
   endfunction

   logic [NB_BITS-1:0] regs [N_REGS];
   logic               step_prev;

   logic [5:0]         opcode;
   logic [NB_REG-1:0]  rs, rt, rd;
   logic [15:0]        imm16;
   logic [NB_CTRL-1:0] ctrl;
   logic [NB_BITS-1:0] imm_ext;
   logic [NB_BITS-1:0] rs_val, rt_val, cmp_a, cmp_b;
   logic [NB_REG-1:0]  id_ex_dst;
   logic               is_branch, taken, stall, upd_en;
   logic               load_use, br_alu, br_load;

   assign opcode = i_if_id_instr[31:26];
   assign rs     = i_if_id_instr[25:21];
   assign rt     = i_if_id_instr[20:16];
   assign rd     = i_if_id_instr[15:11];
   assign imm16  = i_if_id_instr[15:0];

   assign rs_val = rf_bypass(rs, regs[rs], i_wb_we, i_wb_addr, i_wb_data);
   assign rt_val = rf_bypass(rt, regs[rt], i_wb_we, i_wb_addr, i_wb_data);
   assign o_reg_data_debug = rf_bypass(i_reg_addr_debug, regs[i_reg_addr_debug],
                                       i_wb_we, i_wb_addr, i_wb_data);

   always_comb begin
      ctrl    = '0;
      imm_ext = {{(NB_BITS-16){imm16[15]}}, imm16};
      case (opcode)
         OP_RTYPE:                         ctrl = CTRL_RTYPE;
         OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: ctrl = CTRL_IMM;
         OP_LW:                            ctrl = CTRL_LW;
         OP_SW:                            ctrl = CTRL_SW;
         default:                          ctrl = '0;
      endcase
      if ((opcode == OP_ANDI) || (opcode == OP_ORI))
         imm_ext = {{(NB_BITS-16){1'b0}}, imm16};
   end

   // Branch operands take the EX/MEM ALU result when it targets them; loads cannot be forwarded here.
   assign cmp_a = (i_mem_reg_we && !i_mem_mem_read && (i_mem_rd == rs) && (i_mem_rd != '0))
                  ? i_mem_alu_data : rs_val;
   assign cmp_b = (i_mem_reg_we && !i_mem_mem_read && (i_mem_rd == rt) && (i_mem_rd != '0))
                  ? i_mem_alu_data : rt_val;

   assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
   assign taken     = ((opcode == OP_BEQ) && (cmp_a == cmp_b)) ||
                      ((opcode == OP_BNE) && (cmp_a != cmp_b));
   assign id_ex_dst = o_id_ex_ctrl[C_REG_DST] ? o_id_ex_rd : o_id_ex_rt;

   assign load_use = o_id_ex_ctrl[C_MEM_READ] && reg_hit(o_id_ex_rt, rs, rt);
   assign br_alu   = is_branch && o_id_ex_ctrl[C_REG_WE] && reg_hit(id_ex_dst, rs, rt);
   assign br_load  = is_branch && i_mem_mem_read && reg_hit(i_mem_rd, rs, rt);
   assign stall    = load_use || br_alu || br_load;

   assign o_pc_we     = !stall;
   assign o_if_id_we  = !stall;
   assign o_ctr_beq   = !stall && taken;
   assign o_ctr_jmp   = !stall && (opcode == OP_J);
   assign o_ctr_flush = o_ctr_beq || o_ctr_jmp;

   assign o_brq_addr = i_if_id_pc + {{(NB_BITS-18){imm16[15]}}, imm16, 2'b00};
   assign o_jmp_addr = {i_if_id_pc[NB_BITS-1:NB_BITS-4], i_if_id_instr[NB_JMP-1:0], 2'b00};

   // In debug mode state advances only on the rising edge of i_step.
   assign upd_en = !i_debug || (i_step && !step_prev);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         step_prev       <= 1'b0;
         o_id_ex_rs_data <= '0;
         o_id_ex_rt_data <= '0;
         o_id_ex_imm     <= '0;
         o_id_ex_rs      <= '0;
         o_id_ex_rt      <= '0;
         o_id_ex_rd      <= '0;
         o_id_ex_opcode  <= '0;
         o_id_ex_ctrl    <= '0;
         for (int i = 0; i < N_REGS; i++)
            regs[i] <= '0;
      end else begin
         if (i_debug)
            step_prev <= i_step;
         if (upd_en) begin
            if (i_wb_we && (i_wb_addr != '0))
               regs[i_wb_addr] <= i_wb_data;
            if (stall) begin
               o_id_ex_rs_data <= '0;
               o_id_ex_rt_data <= '0;
               o_id_ex_imm     <= '0;
               o_id_ex_rs      <= '0;
               o_id_ex_rt      <= '0;
               o_id_ex_rd      <= '0;
               o_id_ex_opcode  <= '0;
               o_id_ex_ctrl    <= '0;
            end else begin
               o_id_ex_rs_data <= rs_val;
               o_id_ex_rt_data <= rt_val;
               o_id_ex_imm     <= imm_ext;
               o_id_ex_rs      <= rs;
               o_id_ex_rt      <= rt;
               o_id_ex_rd      <= rd;
               o_id_ex_opcode  <= opcode;
               o_id_ex_ctrl    <= ctrl;
            end
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the ID stage.
module tb_decode_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] pc, instr, wb_data, mem_alu_data;
   logic [4:0]  wb_addr, mem_rd, reg_addr_dbg;
   logic        wb_we, mem_reg_we, mem_mem_read, dbg, step;

   logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm, brq_addr, jmp_addr, reg_data_dbg;
   logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
   logic [5:0]  id_ex_opcode, id_ex_ctrl;
   logic        ctr_beq, ctr_jmp, ctr_flush, pc_we, if_id_we;

   decode_stage dut (
      .i_clk(clk), .i_rst(rst), .i_if_id_pc(pc), .i_if_id_instr(instr),
      .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_wb_we(wb_we),
      .i_mem_rd(mem_rd), .i_mem_reg_we(mem_reg_we), .i_mem_mem_read(mem_mem_read),
      .i_mem_alu_data(mem_alu_data), .i_debug(dbg), .i_step(step),
      .i_reg_addr_debug(reg_addr_dbg),
      .o_id_ex_rs_data(id_ex_rs_data), .o_id_ex_rt_data(id_ex_rt_data),
      .o_id_ex_imm(id_ex_imm), .o_id_ex_rs(id_ex_rs), .o_id_ex_rt(id_ex_rt),
      .o_id_ex_rd(id_ex_rd), .o_id_ex_opcode(id_ex_opcode), .o_id_ex_ctrl(id_ex_ctrl),
      .o_brq_addr(brq_addr), .o_jmp_addr(jmp_addr), .o_ctr_beq(ctr_beq),
      .o_ctr_jmp(ctr_jmp), .o_ctr_flush(ctr_flush), .o_pc_we(pc_we),
      .o_if_id_we(if_id_we), .o_reg_data_debug(reg_data_dbg)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference model state
   logic [31:0] m_regs [32];
   logic [31:0] m_rs_data, m_rt_data, m_imm;
   logic [4:0]  m_rs, m_rt, m_rd;
   logic [5:0]  m_op, m_ctrl;
   logic        m_step_prev;

   // Model combinational view of the current cycle
   logic        e_stall, e_beq, e_jmp;
   logic [31:0] e_brq, e_jaddr, e_dbg;
   logic [31:0] n_rs_data, n_rt_data, n_imm;
   logic [5:0]  n_ctrl;

   // Snapshot of DUT combinational outputs for directed checks
   logic        c_pc_we, c_if_id_we, c_beq, c_jmp, c_flush;
   logic [31:0] c_brq, c_jaddr;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (wb_we && wb_addr == a) return wb_data;
      return m_regs[a];
   endfunction

   function automatic bit uses(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
      return d != 0 && (d == a || d == b);
   endfunction

   function automatic logic [31:0] fwd(input logic [4:0] a);
      if (mem_reg_we && !mem_mem_read && mem_rd == a && a != 0) return mem_alu_data;
      return m_read(a);
   endfunction

   task automatic model_eval();
      logic [5:0]  op;
      logic [4:0]  fs, ft;
      logic [31:0] a, b;
      bit          br;
      op = instr[31:26];
      fs = instr[25:21];
      ft = instr[20:16];
      case (op)
         6'h00:                      n_ctrl = 6'b100001;
         6'h08, 6'h0C, 6'h0D, 6'h0F: n_ctrl = 6'b100010;
         6'h23:                      n_ctrl = 6'b110110;
         6'h2B:                      n_ctrl = 6'b001010;
         default:                    n_ctrl = 6'b000000;
      endcase
      if (op == 6'h0C || op == 6'h0D) n_imm = {16'h0, instr[15:0]};
      else                            n_imm = 32'($signed(instr[15:0]));
      n_rs_data = m_read(fs);
      n_rt_data = m_read(ft);
      br = (op == 6'h04 || op == 6'h05);
      e_stall = (m_ctrl[4] && uses(m_rt, fs, ft))
             || (br && m_ctrl[5] && uses(m_ctrl[0] ? m_rd : m_rt, fs, ft))
             || (br && mem_mem_read && uses(mem_rd, fs, ft));
      a = fwd(fs);
      b = fwd(ft);
      e_beq   = !e_stall && ((op == 6'h04 && a == b) || (op == 6'h05 && a != b));
      e_jmp   = !e_stall && op == 6'h02;
      e_brq   = pc + 32'($signed(instr[15:0])) * 32'd4;
      e_jaddr = (pc & 32'hF000_0000) | ({6'd0, instr[25:0]} << 2);
      e_dbg   = m_read(reg_addr_dbg);
   endtask

   task automatic model_clock();
      bit upd;
      if (rst) begin
         foreach (m_regs[i]) m_regs[i] = 0;
         {m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_rd, m_op, m_ctrl} = '0;
         m_step_prev = 0;
         return;
      end
      upd = !dbg || (step && !m_step_prev);
      if (dbg) m_step_prev = step;
      if (!upd) return;
      if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (e_stall)
         {m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_rd, m_op, m_ctrl} = '0;
      else begin
         m_rs_data = n_rs_data; m_rt_data = n_rt_data; m_imm = n_imm;
         m_rs = instr[25:21]; m_rt = instr[20:16]; m_rd = instr[15:11];
         m_op = instr[31:26]; m_ctrl = n_ctrl;
      end
   endtask

   // Inputs are applied right after a negedge; this checks one full cycle.
   task automatic run_cycle();
      #1;
      model_eval();
      c_pc_we = pc_we; c_if_id_we = if_id_we; c_beq = ctr_beq; c_jmp = ctr_jmp;
      c_flush = ctr_flush; c_brq = brq_addr; c_jaddr = jmp_addr;
      chk("pc_we",     32'(pc_we),     32'(!e_stall));
      chk("if_id_we",  32'(if_id_we),  32'(!e_stall));
      chk("ctr_beq",   32'(ctr_beq),   32'(e_beq));
      chk("ctr_jmp",   32'(ctr_jmp),   32'(e_jmp));
      chk("ctr_flush", 32'(ctr_flush), 32'(e_beq | e_jmp));
      chk("brq_addr",  brq_addr, e_brq);
      chk("jmp_addr",  jmp_addr, e_jaddr);
      chk("reg_dbg",   reg_data_dbg, e_dbg);
      @(posedge clk);
      model_clock();
      #1;
      chk("ex_rs_data", id_ex_rs_data, m_rs_data);
      chk("ex_rt_data", id_ex_rt_data, m_rt_data);
      chk("ex_imm",     id_ex_imm,     m_imm);
      chk("ex_rs",      32'(id_ex_rs), 32'(m_rs));
      chk("ex_rt",      32'(id_ex_rt), 32'(m_rt));
      chk("ex_rd",      32'(id_ex_rd), 32'(m_rd));
      chk("ex_opcode",  32'(id_ex_opcode), 32'(m_op));
      chk("ex_ctrl",    32'(id_ex_ctrl),   32'(m_ctrl));
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] op;
      case ($urandom_range(0, 11))
         0, 1:    op = 6'h00;
         2:       op = 6'h08;
         3:       op = 6'h0C;
         4:       op = 6'h0D;
         5:       op = 6'h0F;
         6:       op = 6'h23;
         7:       op = 6'h2B;
         8:       op = 6'h04;
         9:       op = 6'h05;
         10:      op = 6'h02;
         default: op = 6'($urandom);
      endcase
      return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 11'($urandom)};
   endfunction

   initial begin
      rst = 1; pc = 32'h4; instr = 0; wb_addr = 0; wb_data = 0; wb_we = 0;
      mem_rd = 0; mem_reg_we = 0; mem_mem_read = 0; mem_alu_data = 0;
      dbg = 0; step = 0; reg_addr_dbg = 0;
      foreach (m_regs[i]) m_regs[i] = 0;
      {m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_rd, m_op, m_ctrl} = '0;
      m_step_prev = 0;
      @(negedge clk);
      run_cycle();
      chk("rst_ctrl", 32'(id_ex_ctrl), 32'd0);
      chk("rst_imm", id_ex_imm, 32'd0);
      chk("rst_pc_we", 32'(c_pc_we), 32'd1);
      chk("rst_brq", c_brq, 32'h4);
      rst = 0;

      // addi $1,$0,5
      instr = {6'h08, 5'd0, 5'd1, 16'd5};
      run_cycle();
      chk("addi_ctrl", 32'(id_ex_ctrl), 32'b100010);
      chk("addi_imm", id_ex_imm, 32'd5);
      chk("addi_rt", 32'(id_ex_rt), 32'd1);
      chk("addi_flush", 32'(c_flush), 32'd0);

      // lw $2,0($1) then add $3,$2,$2 -> one bubble
      instr = {6'h23, 5'd1, 5'd2, 16'd0};
      run_cycle();
      instr = {6'h00, 5'd2, 5'd2, 5'd3, 5'd0, 6'h20};
      run_cycle();
      chk("lu_pc_we", 32'(c_pc_we), 32'd0);
      chk("lu_if_id_we", 32'(c_if_id_we), 32'd0);
      chk("lu_bubble", 32'(id_ex_ctrl), 32'd0);
      run_cycle();
      chk("lu_issue_ctrl", 32'(id_ex_ctrl), 32'b100001);
      chk("lu_issue_rd", 32'(id_ex_rd), 32'd3);

      // $4 = $5 = 7, then beq/bne at PC+4 = 0x14
      instr = 0;
      wb_we = 1; wb_addr = 4; wb_data = 7;
      run_cycle();
      wb_addr = 5;
      run_cycle();
      wb_we = 0;
      pc = 32'h14; instr = {6'h04, 5'd4, 5'd5, 16'd3};
      run_cycle();
      chk("beq_taken", 32'(c_beq), 32'd1);
      chk("beq_target", c_brq, 32'h20);
      chk("beq_flush", 32'(c_flush), 32'd1);
      instr = {6'h05, 5'd4, 5'd5, 16'd3};
      run_cycle();
      chk("bne_not_taken", 32'(c_beq), 32'd0);

      // j 0x100
      pc = 32'h8000_0004; instr = {6'h02, 26'h100};
      run_cycle();
      chk("j_addr", c_jaddr, 32'h8000_0400);
      chk("j_ctr", 32'(c_jmp), 32'd1);
      chk("j_flush", 32'(c_flush), 32'd1);

      // Same-cycle write-through, and WB to $0
      pc = 32'h20; instr = {6'h00, 5'd6, 5'd0, 5'd7, 5'd0, 6'h20};
      wb_we = 1; wb_addr = 6; wb_data = 32'hDEAD;
      run_cycle();
      chk("wt_rs_data", id_ex_rs_data, 32'hDEAD);
      instr = {6'h00, 5'd0, 5'd0, 5'd8, 5'd0, 6'h20};
      wb_addr = 0; wb_data = 32'h1234;
      run_cycle();
      chk("r0_rs_data", id_ex_rs_data, 32'd0);
      wb_we = 0;

      // Debug stepping
      dbg = 1; step = 0; instr = {6'h08, 5'd0, 5'd1, 16'h00AA};
      run_cycle();
      step = 1;
      instr = {6'h08, 5'd0, 5'd1, 16'h0011}; run_cycle();
      instr = {6'h08, 5'd0, 5'd1, 16'h0022}; run_cycle();
      instr = {6'h08, 5'd0, 5'd1, 16'h0033}; run_cycle();
      chk("dbg_one_update", id_ex_imm, 32'h11);
      step = 0; instr = {6'h08, 5'd0, 5'd1, 16'h0044}; run_cycle();
      chk("dbg_hold", id_ex_imm, 32'h11);
      step = 1; instr = {6'h08, 5'd0, 5'd1, 16'h0055}; run_cycle();
      chk("dbg_second", id_ex_imm, 32'h55);
      dbg = 0; step = 0;

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         rst          = ($urandom_range(0, 63) == 0);
         pc           = $urandom & 32'hFFFF_FFFC;
         instr        = rand_instr();
         wb_we        = $urandom_range(0, 1);
         wb_addr      = 5'($urandom_range(0, 7));
         wb_data      = $urandom_range(0, 3);
         mem_rd       = 5'($urandom_range(0, 7));
         mem_reg_we   = $urandom_range(0, 1);
         mem_mem_read = ($urandom_range(0, 3) == 0);
         mem_alu_data = $urandom_range(0, 3);
         reg_addr_dbg = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 31) == 0) dbg = ~dbg;
         step         = $urandom_range(0, 1);
         run_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
